// File: rtl/wash_phase_timer.sv
// Phase timer for the washing-machine controller: times each timed phase against
// shadowed durations, raising sticky done flags and exporting remaining/elapsed time.
module wash_phase_timer #(
   parameter int CNT_W      = 8,
   parameter int PRESCALE   = 1,
   parameter int DELAY_TIME = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [8:0]       state,
   input  logic             pause,
   input  logic [CNT_W-1:0] fill_time,
   input  logic [CNT_W-1:0] wash_time,
   input  logic [CNT_W-1:0] rinse_time,
   input  logic [CNT_W-1:0] spin_time,
   input  logic [CNT_W-1:0] drain_time,
   output logic             sig_Delay,
   output logic             sig_Full,
   output logic             sig_Wash_Completed,
   output logic             sig_Rinse_Completed,
   output logic             sig_Spin_Completed,
   output logic             sig_Drain_Completed,
   output logic [CNT_W-1:0] remaining,
   output logic [CNT_W+3:0] elapsed,
   output logic             sig_Bad_State
);

   localparam int                ELW       = CNT_W + 4;
   localparam int                PS_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0]   PS_LAST   = PS_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0]  DELAY_DUR = CNT_W'(DELAY_TIME);
   localparam logic [8:0]        ST_IDLE   = 9'b0_0000_0001;

   function automatic logic is_onehot(input logic [8:0] s);
      return (s != '0) && ((s & (s - 9'd1)) == '0);
   endfunction

   // Timed-phase vector is one-hot, so an AND-OR mux selects the duration.
   function automatic logic [CNT_W-1:0] pick_dur(
      input logic [5:0]       ph,
      input logic [CNT_W-1:0] d0,
      input logic [CNT_W-1:0] d1,
      input logic [CNT_W-1:0] d2,
      input logic [CNT_W-1:0] d3,
      input logic [CNT_W-1:0] d4,
      input logic [CNT_W-1:0] d5
   );
      return ({CNT_W{ph[0]}} & d0) | ({CNT_W{ph[1]}} & d1) | ({CNT_W{ph[2]}} & d2)
           | ({CNT_W{ph[3]}} & d3) | ({CNT_W{ph[4]}} & d4) | ({CNT_W{ph[5]}} & d5);
   endfunction

   function automatic logic [ELW-1:0] sat_inc(input logic [ELW-1:0] e);
      return (e == '1) ? e : e + ELW'(1);
   endfunction

   logic [8:0]       state_q;
   logic [PS_W-1:0]  presc;
   logic [CNT_W-1:0] phase_cnt;
   logic [CNT_W-1:0] fill_sh, wash_sh, rinse_sh, spin_sh, drain_sh;
   logic [5:0]       flags;
   logic [ELW-1:0]   elapsed_q;
   logic             bad_q;

   logic             legal_in, legal_q, idle_in, changed, timed_in, timed_q;
   logic [5:0]       ph_in, ph_q;
   logic [CNT_W-1:0] dur_in, dur_q, cnt_inc;
   logic             flag_cur, count_en, tick, set_flag;

   always_comb begin
      legal_in = is_onehot(state);
      legal_q  = is_onehot(state_q);
      idle_in  = legal_in && state[0];
      ph_in    = legal_in ? state[6:1] : 6'b0;
      ph_q     = legal_q ? state_q[6:1] : 6'b0;
      timed_in = |ph_in;
      timed_q  = |ph_q;
      changed  = (state != state_q);
      dur_in   = pick_dur(ph_in, DELAY_DUR, fill_sh, wash_sh, rinse_sh, spin_sh, drain_sh);
      dur_q    = pick_dur(ph_q, DELAY_DUR, fill_sh, wash_sh, rinse_sh, spin_sh, drain_sh);
      cnt_inc  = phase_cnt + CNT_W'(1);
      flag_cur = |(flags & ph_in);
      count_en = timed_in && !changed && !pause && !flag_cur;
      tick     = count_en && (presc == PS_LAST);
      // A zero duration completes on its first cycle, even the change cycle.
      set_flag = timed_in && ((dur_in == '0) || (tick && (cnt_inc == dur_in)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         bad_q     <= 1'b0;
         presc     <= '0;
         phase_cnt <= '0;
         elapsed_q <= '0;
         flags     <= '0;
         fill_sh   <= '0;
         wash_sh   <= '0;
         rinse_sh  <= '0;
         spin_sh   <= '0;
         drain_sh  <= '0;
      end else begin
         state_q <= state;
         bad_q   <= !legal_in;
         if (idle_in) begin
            fill_sh   <= fill_time;
            wash_sh   <= wash_time;
            rinse_sh  <= rinse_time;
            spin_sh   <= spin_time;
            drain_sh  <= drain_time;
            presc     <= '0;
            phase_cnt <= '0;
            elapsed_q <= '0;
            flags     <= '0;
         end else if (timed_in) begin
            if (changed) begin
               presc     <= '0;
               phase_cnt <= '0;
            end else if (tick) begin
               presc     <= '0;
               phase_cnt <= cnt_inc;
               elapsed_q <= sat_inc(elapsed_q);
            end else if (count_en) begin
               presc <= presc + PS_W'(1);
            end
            if (set_flag) flags <= flags | ph_in;
         end
         // COMPLETE, ERROR and illegal encodings hold everything.
      end
   end

   always_comb begin
      remaining = '0;
      if (timed_q && (phase_cnt <= dur_q)) remaining = dur_q - phase_cnt;
   end

   assign sig_Delay           = flags[0];
   assign sig_Full            = flags[1];
   assign sig_Wash_Completed  = flags[2];
   assign sig_Rinse_Completed = flags[3];
   assign sig_Spin_Completed  = flags[4];
   assign sig_Drain_Completed = flags[5];
   assign elapsed             = elapsed_q;
   assign sig_Bad_State       = bad_q;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Directed bench for wash_phase_timer: three instances (PRESCALE 1, 2, 4) share
// the stimulus; each scenario checks the instance whose prescale it targets.
module tb_wash_phase_timer;

   localparam int CNT_W = 8;
   localparam logic [8:0] S_IDLE     = 9'b0_0000_0001;
   localparam logic [8:0] S_READY    = 9'b0_0000_0010;
   localparam logic [8:0] S_FILL     = 9'b0_0000_0100;
   localparam logic [8:0] S_WASH     = 9'b0_0000_1000;
   localparam logic [8:0] S_RINSE    = 9'b0_0001_0000;
   localparam logic [8:0] S_SPIN     = 9'b0_0010_0000;
   localparam logic [8:0] S_DRAIN    = 9'b0_0100_0000;
   localparam logic [8:0] S_COMPLETE = 9'b0_1000_0000;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [8:0]       state;
   logic             pause;
   logic [CNT_W-1:0] fill_time, wash_time, rinse_time, spin_time, drain_time;

   wire [5:0]       flg1, flg2, flg4;
   wire [CNT_W-1:0] rem1, rem2, rem4;
   wire [CNT_W+3:0] el1, el2, el4;
   wire             bad1, bad2, bad4;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   wash_phase_timer #(.CNT_W(CNT_W), .PRESCALE(1), .DELAY_TIME(1)) u1 (
      .clk(clk), .rst_n(rst_n), .state(state), .pause(pause),
      .fill_time(fill_time), .wash_time(wash_time), .rinse_time(rinse_time),
      .spin_time(spin_time), .drain_time(drain_time),
      .sig_Delay(flg1[0]), .sig_Full(flg1[1]), .sig_Wash_Completed(flg1[2]),
      .sig_Rinse_Completed(flg1[3]), .sig_Spin_Completed(flg1[4]),
      .sig_Drain_Completed(flg1[5]), .remaining(rem1), .elapsed(el1),
      .sig_Bad_State(bad1));

   wash_phase_timer #(.CNT_W(CNT_W), .PRESCALE(2), .DELAY_TIME(1)) u2 (
      .clk(clk), .rst_n(rst_n), .state(state), .pause(pause),
      .fill_time(fill_time), .wash_time(wash_time), .rinse_time(rinse_time),
      .spin_time(spin_time), .drain_time(drain_time),
      .sig_Delay(flg2[0]), .sig_Full(flg2[1]), .sig_Wash_Completed(flg2[2]),
      .sig_Rinse_Completed(flg2[3]), .sig_Spin_Completed(flg2[4]),
      .sig_Drain_Completed(flg2[5]), .remaining(rem2), .elapsed(el2),
      .sig_Bad_State(bad2));

   wash_phase_timer #(.CNT_W(CNT_W), .PRESCALE(4), .DELAY_TIME(1)) u4 (
      .clk(clk), .rst_n(rst_n), .state(state), .pause(pause),
      .fill_time(fill_time), .wash_time(wash_time), .rinse_time(rinse_time),
      .spin_time(spin_time), .drain_time(drain_time),
      .sig_Delay(flg4[0]), .sig_Full(flg4[1]), .sig_Wash_Completed(flg4[2]),
      .sig_Rinse_Completed(flg4[3]), .sig_Spin_Completed(flg4[4]),
      .sig_Drain_Completed(flg4[5]), .remaining(rem4), .elapsed(el4),
      .sig_Bad_State(bad4));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge; cycle N starts here.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; state = S_IDLE; pause = 1'b0;
      fill_time = '0; wash_time = '0; rinse_time = '0; spin_time = '0; drain_time = '0;
      step(); step();
      check_eq("rst_flags",   {12'd0, flg1, flg2, flg4}, 32'd0);
      check_eq("rst_rem",     {8'd0, rem1, rem2, rem4}, 32'd0);
      check_eq("rst_elapsed", {el1, el2, el4} == '0, 32'd1);
      check_eq("rst_bad",     {bad1, bad2, bad4}, 32'd0);
      rst_n = 1'b1;

      // WASH=30, PRESCALE=1: flag first visible at cycle 31.
      state = S_IDLE; wash_time = 8'd30; step();
      state = S_WASH;                        // cycle 0
      step();          check_eq("wash_rem_c1", rem1, 32'd30);
      repeat (29) step();
      check_eq("wash_flag_c30", flg1[2], 32'd0);
      check_eq("wash_rem_c30",  rem1, 32'd1);
      step();
      check_eq("wash_flag_c31", flg1[2], 32'd1);
      check_eq("wash_rem_c31",  rem1, 32'd0);
      check_eq("wash_el_c31",   el1, 32'd30);

      // FILL=3, PRESCALE=4: ticks at 4,8,12; flag at 13.
      state = S_IDLE; fill_time = 8'd3; step();
      state = S_FILL;                        // cycle 0
      step();             check_eq("fill_rem_c1", rem4, 32'd3);
      repeat (3) step();  check_eq("fill_rem_c4", rem4, 32'd3);
      step();             check_eq("fill_rem_c5", rem4, 32'd2);
      repeat (4) step();  check_eq("fill_rem_c9", rem4, 32'd1);
      repeat (3) step();  check_eq("fill_flag_c12", flg4[1], 32'd0);
      step();
      check_eq("fill_flag_c13", flg4[1], 32'd1);
      check_eq("fill_rem_c13",  rem4, 32'd0);
      check_eq("fill_el_c13",   el4, 32'd3);

      // RINSE=5, PRESCALE=2, paused cycles 3..9: flag at 18 instead of 11.
      state = S_IDLE; rinse_time = 8'd5; step();
      state = S_RINSE;                       // cycle 0
      step(); step(); step();                // cycle 3
      pause = 1'b1;
      check_eq("rinse_el_c3",  el2, 32'd1);
      check_eq("rinse_rem_c3", rem2, 32'd4);
      repeat (7) step();                     // cycle 10
      pause = 1'b0;
      check_eq("rinse_el_c10",  el2, 32'd1);
      check_eq("rinse_rem_c10", rem2, 32'd4);
      check_eq("rinse_flag_c10", flg2[3], 32'd0);
      repeat (7) step();  check_eq("rinse_flag_c17", flg2[3], 32'd0);
      step();
      check_eq("rinse_flag_c18", flg2[3], 32'd1);
      check_eq("rinse_el_c18",   el2, 32'd5);

      // SPIN=0 completes at cycle 1; WASH edit outside IDLE is ignored.
      state = S_IDLE; spin_time = 8'd0; wash_time = 8'd3; step();
      state = S_SPIN;                        // cycle 0
      check_eq("spin_flag_c0", flg1[4], 32'd0);
      step();
      check_eq("spin_flag_c1", flg1[4], 32'd1);
      check_eq("spin_rem_c1",  rem1, 32'd0);
      state = S_WASH; wash_time = 8'd100;    // change at cycle 1
      step();             check_eq("wash2_rem", rem1, 32'd3);
      repeat (2) step();  check_eq("wash2_flag_early", flg1[2], 32'd0);
      step();
      check_eq("wash2_flag",   flg1[2], 32'd1);
      check_eq("spin_sticky",  flg1[4], 32'd1);
      check_eq("wash2_el",     el1, 32'd3);

      // Illegal two-hot state during FILL freezes counters; legal FILL restarts.
      state = S_IDLE; fill_time = 8'd10; step();
      state = S_FILL;                        // cycle 0
      repeat (4) step();                     // cycle 4
      check_eq("bad_pre_rem", rem1, 32'd7);
      state = 9'b000011000;
      step();                                // cycle 5
      check_eq("bad_flag_c5", bad1, 32'd1);
      check_eq("bad_el_c5",   el1, 32'd3);
      check_eq("bad_rem_c5",  rem1, 32'd0);
      step();                                // cycle 6
      check_eq("bad_el_c6",   el1, 32'd3);
      state = S_FILL;
      step();                                // cycle 7
      check_eq("bad_clr_c7",  bad1, 32'd0);
      check_eq("refill_rem_c7", rem1, 32'd10);
      check_eq("refill_el_c7",  el1, 32'd3);
      step();
      check_eq("refill_rem_c8", rem1, 32'd9);
      check_eq("refill_el_c8",  el1, 32'd4);

      // READY then DRAIN, asynchronous reset between edges.
      state = S_IDLE; drain_time = 8'd50; step();
      state = S_READY;                       // cycle 0
      step(); step();                        // cycle 2
      check_eq("ready_flag", flg1[0], 32'd1);
      state = S_DRAIN;
      repeat (5) step();                     // cycle 7
      check_eq("drain_el_pre",  el1, 32'd5);
      check_eq("drain_rem_pre", rem1, 32'd46);
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst_flags",   {12'd0, flg1, flg2, flg4}, 32'd0);
      check_eq("arst_el",      {el1, el2, el4} == '0, 32'd1);
      check_eq("arst_rem",     {8'd0, rem1, rem2, rem4}, 32'd0);
      state = S_IDLE;
      step(); step();
      rst_n = 1'b1;

      // COMPLETE holds, IDLE afterwards clears flags and elapsed.
      state = S_IDLE; drain_time = 8'd2; step();
      state = S_DRAIN;                       // cycle 0
      repeat (3) step();                     // cycle 3
      check_eq("drain_flag_c3", flg1[5], 32'd1);
      state = S_COMPLETE;
      step();
      check_eq("cmp_flag", flg1[5], 32'd1);
      check_eq("cmp_el",   el1, 32'd2);
      check_eq("cmp_rem",  rem1, 32'd0);
      step();
      check_eq("cmp_el_hold", el1, 32'd2);
      state = S_IDLE;
      step();
      check_eq("idle_flags", {26'd0, flg1}, 32'd0);
      check_eq("idle_el",    el1, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wash_phase_timer.md
# wash_phase_timer

Parametrised phase timer for the washing-machine controller: given the controller's one-hot state, it times READY, FILL, WASH, RINSE, SPIN and DRAIN against durations programmable at run time. It raises sticky completion flags back to the controller and exports remaining and elapsed time for the display. It adds a prescaler, pause and freeze, illegal-state detection, and an asynchronous reset.

## Interface
- CNT_W, 8: width of the phase counter, the duration inputs and `remaining`.
- PRESCALE, 1: clk cycles per time unit (tick); legal range ≥1.
- DELAY_TIME, 1: READY delay in ticks.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- state  in  9  one-hot controller state: IDLE=bit0, READY=1, FILL=2, WASH=3, RINSE=4, SPIN=5, DRAIN=6, COMPLETE=7, ERROR=8.
- pause  in  1  freezes all timing while high (door open).
- fill_time, wash_time, rinse_time, spin_time, drain_time  in  CNT_W each  phase durations in ticks.
- sig_Delay, sig_Full, sig_Wash_Completed, sig_Rinse_Completed, sig_Spin_Completed, sig_Drain_Completed  out  1 each  sticky done flags for READY, FILL, WASH, RINSE, SPIN and DRAIN.
- remaining  out  CNT_W  ticks left in the current timed phase.
- elapsed  out  CNT_W+4  ticks counted since leaving IDLE; saturates at all-ones.
- sig_Bad_State  out  1  registered high while `state` is not one-hot.

## Operation
- Reset (rst_n=0, asynchronous) clears every register: all outputs 0, prescaler 0, phase_cnt 0, state_q = IDLE, shadow durations 0.
- Timed phases: READY (duration DELAY_TIME) and FILL through DRAIN (the shadow durations).
- Durations latch into shadow registers on every cycle with state==IDLE. Input changes outside IDLE are ignored.
- IDLE clears phase_cnt, prescaler, `elapsed` and all six flags.
- State change: a cycle where state != state_q (state_q is the registered previous state).
  - That cycle clears the prescaler and phase_cnt and does not count.
  - Re-entering a phase restarts it from 0.
- Counting: enabled in a timed phase when pause=0, there is no state change, and the phase's flag is 0.
  - Each enabled cycle increments the prescaler. At PRESCALE-1 it wraps to 0 and produces a tick.
  - On a tick: phase_cnt += 1 and `elapsed` += 1 (saturating).
  - If phase_cnt+1 == duration on that tick, the phase flag sets on the same edge.
- Duration 0: the flag sets at the end of the first cycle in the phase, including the state-change cycle, with no tick.
- Once a flag is set, phase_cnt holds at the duration and the prescaler stops.
- Flags are sticky until IDLE or reset. Flags from earlier phases stay set.
- `remaining`: duration − phase_cnt in a timed phase, otherwise 0. It is combinational from registers and never negative.
- COMPLETE and ERROR hold all counters and flags; no counting.
- Illegal state (zero-hot or multi-hot):
  - no counting, no clearing, flags held;
  - sig_Bad_State=1 from the next edge until a legal state is registered;
  - state_q still updates.
- Pause: prescaler, phase_cnt and `elapsed` hold exactly. Counting resumes with the next unpaused cycle, with no lost or extra tick.
- Arithmetic is unsigned. phase_cnt cannot exceed CNT_W bits because it stops at the duration.

## Timing
- Entering a phase with duration D>0 at cycle 0 (the change cycle) and no pause:
  - ticks occur at cycles P, 2P … D·P (P = PRESCALE);
  - the flag is visible from cycle D·P+1.
- Duration 0: the flag is visible from cycle 1.
- Each paused cycle delays the flag by exactly one cycle.
- rst_n deassertion is synchronised externally; the first counting cycle after reset is the first cycle with rst_n=1.
- A simultaneous state change and pause resolves as the change: counters clear.
- Reset mid-phase: flags and counters drop to 0 immediately, without waiting for clk.

## Test plan
- PRESCALE=1, wash_time=30, state IDLE→WASH at cycle 0 → sig_Wash_Completed first high at cycle 31; remaining=0 at cycle 31; elapsed=30.
- PRESCALE=4, fill_time=3 → sig_Full first high at cycle 13; remaining steps 3,2,1,0 at cycles 5,9,13.
- PRESCALE=2, rinse_time=5, pause high for 7 cycles mid-phase → sig_Rinse_Completed high at cycle 18, not 11; counters frozen during pause.
- spin_time=0 → sig_Spin_Completed high at cycle 1; wash_time changed while in WASH → no effect on the current run.
- state=9'b000011000 during FILL → sig_Bad_State high next cycle, counters frozen; legal FILL again → counting restarts from 0.
- rst_n low mid-DRAIN for 1 ns between clk edges → all outputs 0 immediately. IDLE after COMPLETE → all flags and elapsed cleared next edge.
